// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the nibble-serial adder/subtractor family.
//   sub_state_t : control states of the nibble-serial subtractor
//   NIBBLE_W    : width of one processing step
package arith_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/sub4_nibble.sv
// Combinational 4-bit subtract with borrow: {bo, d} = a - b - bin.
// Ports:
//   a, b : 4-bit minuend / subtrahend nibbles
//   bin  : borrow-in
//   d    : 4-bit difference nibble
//   bo   : borrow-out (1 when a < b + bin)
module sub4_nibble
    import arith_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bo
);

    logic [NIBBLE_W:0] w_res;

    // One extra bit catches the borrow: it is set exactly when the result went negative.
    assign w_res = {1'b0, a} - {1'b0, b} - {{NIBBLE_W{1'b0}}, bin};
    assign d     = w_res[NIBBLE_W-1:0];
    assign bo    = w_res[NIBBLE_W];

endmodule

// File: rtl/nibble_sub16.sv
// Sequential unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH, computed one nibble per
// clock (LSB first) through a registered borrow chain. Valid/ready handshakes on both sides,
// one operation in flight at a time.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   a, b, bin           : operands, captured on in_valid & in_ready
//   in_valid / in_ready : input handshake (in_ready high only in IDLE)
//   diff, bout, zero    : registered result, borrow-out, result-is-zero flag
//   out_valid/out_ready : output handshake (out_valid high only in DONE)
module nibble_sub16
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NSTEPS = WIDTH / NIBBLE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned CNT_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int unsigned SH_W  = CNT_W + 2;

    sub_state_t         r_state;
    sub_state_t         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic               r_bout;
    logic               r_zero;
    logic [CNT_W-1:0]   r_cnt;

    logic [SH_W-1:0]     w_sh;
    logic [WIDTH-1:0]    w_a_sh;
    logic [WIDTH-1:0]    w_b_sh;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_d;
    logic                w_bo;
    logic [WIDTH-1:0]    w_d_ext;
    logic [WIDTH-1:0]    w_diff_next;
    logic                w_last;

    // Bit offset of the current nibble is simply counter * 4.
    assign w_sh    = {r_cnt, 2'b00};
    assign w_a_sh  = r_a >> w_sh;
    assign w_b_sh  = r_b >> w_sh;
    assign w_a_nib = w_a_sh[NIBBLE_W-1:0];
    assign w_b_nib = w_b_sh[NIBBLE_W-1:0];

    sub4_nibble u_sub4 (
        .a   (w_a_nib),
        .b   (w_b_nib),
        .bin (r_borrow),
        .d   (w_d),
        .bo  (w_bo)
    );

    // diff is cleared on capture, so each step only needs to OR its nibble into place.
    assign w_d_ext     = {{(WIDTH - NIBBLE_W){1'b0}}, w_d};
    assign w_diff_next = r_diff | (w_d_ext << w_sh);
    assign w_last      = (r_cnt == CNT_W'(NSTEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        // The borrow register seeds nibble 0 with the external borrow-in.
                        r_borrow <= bin;
                        r_diff   <= '0;
                        r_bout   <= 1'b0;
                        r_zero   <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_bo;
                    if (w_last) begin
                        r_cnt  <= '0;
                        r_bout <= w_bo;
                        r_zero <= (w_diff_next == '0);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // DONE: result held until the consumer takes it.
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign zero      = r_zero;

endmodule

// File: tb/tb_nibble_sub16.sv
module tb_nibble_sub16;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int last_hs  = -1;

    nibble_sub16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction. hold = cycles with out_ready low in DONE; poke drives junk
    // in_valid/operands while the operation is in flight.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tbin,
                         input int hold, input bit poke);
        longint      t;
        logic [15:0] ed;
        logic        eb;
        logic        ez;
        logic [15:0] sd;
        logic        sb;
        logic        sz;
        int          n;
        int          lhs;
        int          rhs;

        // Reference: plain integer subtraction, wrapped to 16 bits.
        t  = longint'(ta) - longint'(tbv) - longint'(tbin);
        eb = (t < 0);
        ed = t[15:0];
        ez = (ed == 16'h0000);

        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_before_op", 32'(in_ready), 32'd1);

        a         = ta;
        b         = tbv;
        bin       = tbin;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        tick();
        if (last_hs >= 0) chk("hs_spacing_ge6", 32'((cyc - last_hs) >= 6), 32'd1);
        last_hs = cyc;

        in_valid = poke;
        a        = 16'($urandom);
        b        = 16'($urandom);
        bin      = 1'($urandom);

        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
            if (poke) begin
                a = 16'($urandom);
                b = 16'($urandom);
            end
        end
        chk("latency", 32'(n), 32'd4);
        chk("diff", 32'(diff), 32'(ed));
        chk("bout", 32'(bout), 32'(eb));
        chk("zero", 32'(zero), 32'(ez));
        lhs = int'(diff) + int'(tbv) + int'(tbin);
        rhs = int'(ta) + (int'(bout) << 16);
        chk("invariant", 32'(lhs), 32'(rhs));

        sd = diff;
        sb = bout;
        sz = zero;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_diff", 32'(diff), 32'(sd));
            chk("hold_bout", 32'(bout), 32'(sb));
            chk("hold_zero", 32'(zero), 32'(sz));
        end

        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("idle_after_out", 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        rst_n     = 1'b1;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 rst_n  = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(16'h000A, 16'h0000, 1'b0, 0, 1'b0);
        do_op(16'h0000, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
        do_op(16'h1111, 16'h1111, 1'b0, 0, 1'b0);
        do_op(16'h01C0, 16'h00B0, 1'b0, 0, 1'b0);
        do_op(16'h1234, 16'h0ABC, 1'b1, 3, 1'b1);
        // Nothing queued from the pokes: block must sit idle.
        tick();
        chk("no_queue_idle", 32'({in_ready, out_valid}), 32'b10);

        // Reset in the middle of RUN, just after nibble 1 is written.
        a        = 16'hFFFF;
        b        = 16'h0001;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_rst_diff", 32'(diff), 32'd0);
        chk("midrun_rst_bout", 32'(bout), 32'd0);
        chk("midrun_rst_zero", 32'(zero), 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("aborted_no_output", 32'(out_valid), 32'd0);
        end
        do_op(16'hDDDD, 16'h0001, 1'b0, 0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
